// File: rtl/raster_sched_pkg.sv
// Shared types and constants for the raster frame scheduler.
//   sched_state_t    : per-frame sequencer states
//   DEF_MAX_INFLIGHT : default triangle credit depth of the transform chain
package raster_sched_pkg;

  localparam int DEF_MAX_INFLIGHT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_DRAW,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/inflight_credit.sv
// Saturating up/down triangle credit counter.
//   issue      : triangle entered the model_world stage
//   retire     : triangle left the world_camera stage
//   inflight   : registered count of triangles in the chain
//   stall      : count is at MAX_INFLIGHT (decoded from the register)
//   credit_err : sticky; issue at full or retire at empty (reset-only clear)
module inflight_credit
  import raster_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic          retire,
  output logic [CW-1:0] inflight,
  output logic          stall,
  output logic          credit_err
);

  localparam logic [CW-1:0] FULL = CW'(MAX_INFLIGHT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= '0;
      credit_err <= 1'b0;
    end else begin
      // issue+retire together cancel out, even at the limits
      unique case ({issue, retire})
        2'b10: if (inflight == FULL) credit_err <= 1'b1;
               else                  inflight   <= inflight + CW'(1);
        2'b01: if (inflight == '0)   credit_err <= 1'b1;
               else                  inflight   <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  assign stall = (inflight == FULL);

endmodule

// File: rtl/raster_frame_scheduler.sv
// Per-frame raster sequencer: on each accepted frame tick walks the instance
// table (select -> wait memory latency -> start walker -> wait done), then
// drains the transform chain before pulsing frame_done.
//   clk, rst (async, active-low)
//   initial_load_done, frame_tick, inst_count : frame start control
//   inst_id_rd, inst_start, inst_done         : raster memory / walker handshake
//   tri_issued, tri_retired, stall            : transform chain credit metering
//   frame_busy, frame_done, frame_overrun,
//   credit_err, frame_count                   : status
module raster_frame_scheduler
  import raster_sched_pkg::*;
#(
  parameter int MAX_INST     = 256,
  parameter int INST_W       = $clog2(MAX_INST),
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int MEM_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              initial_load_done,
  input  logic              frame_tick,
  input  logic [INST_W:0]   inst_count,
  output logic [INST_W-1:0] inst_id_rd,
  output logic              inst_start,
  input  logic              inst_done,
  input  logic              tri_issued,
  input  logic              tri_retired,
  output logic              stall,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              frame_overrun,
  output logic              credit_err,
  output logic [15:0]       frame_count
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  sched_state_t      state;
  logic [INST_W:0]   cnt_q;
  logic [INST_W-1:0] idx;
  logic [LW-1:0]     lat_cnt;
  logic [INST_W:0]   idx_nxt;
  logic [CW-1:0]     inflight;

  // one bit wider than idx so idx+1 == cnt_q == MAX_INST compares correctly
  assign idx_nxt    = {1'b0, idx} + {{INST_W{1'b0}}, 1'b1};
  assign inst_id_rd = idx;
  assign frame_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt_q         <= '0;
      idx           <= '0;
      lat_cnt       <= '0;
      inst_start    <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      frame_count   <= '0;
    end else begin
      inst_start    <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= frame_tick && (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          // ticks before the scene is loaded are silently dropped
          if (frame_tick && initial_load_done) begin
            cnt_q   <= inst_count;
            idx     <= '0;
            lat_cnt <= '0;
            state   <= (inst_count != '0) ? S_SELECT : S_DRAIN;
          end
        end
        S_SELECT: begin
          // hold the select for MEM_LAT cycles so memory outputs are valid
          if (lat_cnt == LW'(MEM_LAT - 1)) begin
            state      <= S_START;
            inst_start <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_START: state <= S_DRAW;
        S_DRAW: begin
          if (inst_done) begin
            lat_cnt <= '0;
            if (idx_nxt < cnt_q) begin
              idx   <= idx_nxt[INST_W-1:0];
              state <= S_SELECT;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (inflight == '0) begin
            state       <= S_DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  inflight_credit #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CW          (CW)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .issue     (tri_issued),
    .retire    (tri_retired),
    .inflight  (inflight),
    .stall     (stall),
    .credit_err(credit_err)
  );

endmodule
